// File: rtl/bg_tile_pkg.sv
// Shared types and constants for the background tile renderer.
// Tile-word layout, tile-map geometry and the RGB444 colour key.
package bg_tile_pkg;

    localparam int unsigned TILE_W    = 16;
    localparam int unsigned TILE_COLS = 40;
    localparam int unsigned TILE_ROWS = 30;

    // Tile-map word bit positions
    localparam int unsigned TW_COL_LSB = 0;
    localparam int unsigned TW_ROW_LSB = 3;
    localparam int unsigned TW_XFLIP   = 6;
    localparam int unsigned TW_YFLIP   = 7;
    localparam int unsigned TW_EN      = 8;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t COLOR_KEY = 12'hF0F;

    typedef struct packed {
        logic       en;
        logic       yflip;
        logic       xflip;
        logic [2:0] row;
        logic [2:0] col;
    } tile_attr_t;

    function automatic tile_attr_t unpack_tile_word(input logic [8:0] w);
        tile_attr_t a;
        a.col   = w[TW_COL_LSB +: 3];
        a.row   = w[TW_ROW_LSB +: 3];
        a.xflip = w[TW_XFLIP];
        a.yflip = w[TW_YFLIP];
        a.en    = w[TW_EN];
        return a;
    endfunction

endpackage

// File: rtl/tile_attr_decode.sv
// S1->S2 stage: applies tile flips to the in-tile pixel offset and forms the
// tile-sheet ROM address {row, col, fy, fx}; forwards the tile enable.
module tile_attr_decode
    import bg_tile_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  tile_attr_t  attr,
    input  logic [3:0]  px,
    input  logic [3:0]  py,
    output logic [13:0] sheet_addr,
    output logic        tile_en
);

    logic [3:0] fx;
    logic [3:0] fy;

    always_comb begin
        fx = attr.xflip ? (4'hF - px) : px;
        fy = attr.yflip ? (4'hF - py) : py;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sheet_addr <= '0;
            tile_en    <= 1'b0;
        end else begin
            sheet_addr <= {attr.row, attr.col, fy, fx};
            tile_en    <= attr.en;
        end
    end

endmodule

// File: rtl/bg_tile_renderer.sv
// Four-stage, never-stalling background tile renderer: x/y -> tile-map read ->
// sheet ROM read -> registered RGB444 pixel. Define BG_COLOR_KEY_EN for colour keying.
module bg_tile_renderer
    import bg_tile_pkg::*;
#(
    parameter int unsigned TILE_W    = bg_tile_pkg::TILE_W,
    parameter int unsigned TILE_COLS = bg_tile_pkg::TILE_COLS,
    parameter int unsigned TILE_ROWS = bg_tile_pkg::TILE_ROWS,
    parameter int unsigned LATENCY   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [3:0]  bg_x_offset,
    output logic [15:0] bg_rd_addr,
    input  logic [31:0] bg_rd_data,
    output logic [13:0] sheet_addr,
    input  logic [11:0] sheet_data,
    output logic [11:0] pix_rgb,
    output logic        pix_opaque,
    output logic        pix_valid
);

    localparam int unsigned TileShift = $clog2(TILE_W);
    localparam int unsigned VDepth    = LATENCY - 1;

    logic [10:0]       sx;
    logic [6:0]        tcol_raw;
    logic [6:0]        tcol;
    logic [5:0]        trow;
    logic [15:0]       rd_addr_d;
    logic              active;

    logic [VDepth-1:0] valid_q;
    logic [3:0]        px0_q, py0_q;
    logic [3:0]        px1_q, py1_q;
    tile_attr_t        attr_q;
    logic              tile_en;
    logic              pix_opaque_d;
    logic              unused_word_bits;

    assign unused_word_bits = ^bg_rd_data[31:9];

    // Max sx is 639+15, so one subtract is enough to wrap the column.
    always_comb begin
        sx        = {1'b0, x} + {7'b0, bg_x_offset};
        tcol_raw  = 7'(sx >> TileShift);
        tcol      = (tcol_raw >= 7'(TILE_COLS)) ? tcol_raw - 7'(TILE_COLS) : tcol_raw;
        trow      = 6'(y >> TileShift);
        rd_addr_d = 16'(trow) * 16'(TILE_COLS) + 16'(tcol);
        active    = video_on && (y < 10'(TILE_ROWS * TILE_W)) && (trow < 6'(TILE_ROWS));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bg_rd_addr <= '0;
            valid_q    <= '0;
            px0_q      <= '0;
            py0_q      <= '0;
            px1_q      <= '0;
            py1_q      <= '0;
            attr_q     <= '0;
        end else begin
            bg_rd_addr <= rd_addr_d;
            valid_q    <= {valid_q[VDepth-2:0], active};
            px0_q      <= sx[3:0];
            py0_q      <= y[3:0];
            px1_q      <= px0_q;
            py1_q      <= py0_q;
            attr_q     <= unpack_tile_word(bg_rd_data[8:0]);
        end
    end

    tile_attr_decode u_attr_decode (
        .clk        (clk),
        .reset_n    (reset_n),
        .attr       (attr_q),
        .px         (px1_q),
        .py         (py1_q),
        .sheet_addr (sheet_addr),
        .tile_en    (tile_en)
    );

    always_comb begin
`ifdef BG_COLOR_KEY_EN
        pix_opaque_d = valid_q[VDepth-1] & tile_en & (sheet_data != COLOR_KEY);
`else
        pix_opaque_d = valid_q[VDepth-1] & tile_en;
`endif
    end

    // Colour is only passed through for drawn pixels; everything else is black.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_rgb    <= '0;
            pix_opaque <= 1'b0;
            pix_valid  <= 1'b0;
        end else begin
            pix_rgb    <= pix_opaque_d ? sheet_data : 12'h000;
            pix_opaque <= pix_opaque_d;
            pix_valid  <= valid_q[VDepth-1];
        end
    end

endmodule

// File: tb/tb_bg_tile_renderer.sv
// Scoreboard bench for bg_tile_renderer: issued pixels push expected addresses and
// pixels computed from the tile rules; a negedge monitor pops and compares.
module tb_bg_tile_renderer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        video_on = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [3:0]  bg_x_offset = '0;
    logic [15:0] bg_rd_addr;
    logic [31:0] bg_rd_data;
    logic [13:0] sheet_addr;
    logic [11:0] sheet_data;
    logic [11:0] pix_rgb;
    logic        pix_opaque;
    logic        pix_valid;

    always #5 clk = ~clk;

    logic [31:0] map_mem [0:65535];
    logic [11:0] rom     [0:16383];

    // Memories answer within the cycle after the registered address.
    assign bg_rd_data = map_mem[bg_rd_addr];
    assign sheet_data = rom[sheet_addr];

    bg_tile_renderer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .video_on    (video_on),
        .x           (x),
        .y           (y),
        .bg_x_offset (bg_x_offset),
        .bg_rd_addr  (bg_rd_addr),
        .bg_rd_data  (bg_rd_data),
        .sheet_addr  (sheet_addr),
        .sheet_data  (sheet_data),
        .pix_rgb     (pix_rgb),
        .pix_opaque  (pix_opaque),
        .pix_valid   (pix_valid)
    );

    typedef struct {
        int          due;
        logic [15:0] val;
    } addr_exp_t;

    typedef struct {
        int          due;
        logic        v;
        logic        o;
        logic [11:0] rgb;
    } pix_exp_t;

    addr_exp_t rd_q[$];
    addr_exp_t sh_q[$];
    pix_exp_t  px_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic stale(input string name, input int due);
        checks++;
        failures++;
        $display("FAIL %s cycle=%0d got=no-compare expected=compare-at-%0d", name, cyc, due);
    endtask

    // Monitor
    addr_exp_t ae;
    pix_exp_t  pe;
    always @(negedge clk) begin
        if (reset_n) begin
            if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
                ae = rd_q.pop_front();
                if (ae.due < cyc) stale("bg_rd_addr", ae.due);
                else check("bg_rd_addr", int'(bg_rd_addr), int'(ae.val));
            end
            if (sh_q.size() > 0 && sh_q[0].due <= cyc) begin
                ae = sh_q.pop_front();
                if (ae.due < cyc) stale("sheet_addr", ae.due);
                else check("sheet_addr", int'(sheet_addr), int'(ae.val));
            end
            if (px_q.size() > 0 && px_q[0].due <= cyc) begin
                pe = px_q.pop_front();
                if (pe.due < cyc) stale("pix", pe.due);
                else begin
                    check("pix_valid", int'(pix_valid), int'(pe.v));
                    check("pix_opaque", int'(pix_opaque), int'(pe.o));
                    check("pix_rgb", int'(pix_rgb), int'(pe.rgb));
                end
            end
        end
    end

    // Reference model: drive one pixel, push its expected results, advance one clock.
    task automatic issue(input int xi, input int yi, input int offi, input bit von);
        int sx, tcol, trow, addr, px, py, fx, fy, s;
        logic [31:0] w;
        logic [11:0] d;
        bit act, opq;
        x = 10'(xi);
        y = 10'(yi);
        bg_x_offset = 4'(offi);
        video_on = von;
        sx = xi + offi;
        tcol = sx / 16;
        if (tcol >= 40) tcol -= 40;
        trow = yi / 16;
        addr = trow * 40 + tcol;
        act = von && (yi < 480);
        w = map_mem[addr];
        px = sx % 16;
        py = yi % 16;
        fx = w[6] ? 15 - px : px;
        fy = w[7] ? 15 - py : py;
        s = int'(w[5:3]) * 2048 + int'(w[2:0]) * 256 + fy * 16 + fx;
        d = rom[s];
`ifdef BG_COLOR_KEY_EN
        opq = act && w[8] && (d != 12'hF0F);
`else
        opq = act && w[8];
`endif
        rd_q.push_back('{due: cyc + 1, val: 16'(addr)});
        sh_q.push_back('{due: cyc + 3, val: 16'(s)});
        px_q.push_back('{due: cyc + 4, v: act, o: opq, rgb: opq ? d : 12'h000});
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) px_q.push_back('{due: cyc + i, v: 1'b0, o: 1'b0, rgb: 12'h000});
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) map_mem[i] = $urandom;
        for (int i = 0; i < 16384; i++) rom[i] = ($urandom_range(0, 15) == 0) ? 12'hF0F : 12'($urandom);
        map_mem[80] = 32'hDEAD_010A;   // enabled, col 2, row 1, no flip
        map_mem[0]  = 32'h0000_01F5;   // enabled, both flips, col 5, row 6
        map_mem[1]  = 32'hFFFF_FE00;   // disabled tile, junk in ignored bits
        map_mem[2]  = 32'h0000_0123;   // enabled, col 3, row 4
        for (int i = 0; i < 256; i++) rom[4 * 2048 + 3 * 256 + i] = 12'hF0F;

        #2;
        reset_n = 1'b0;
        #1;
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_pix_opaque", int'(pix_opaque), 0);
        check("rst_pix_rgb", int'(pix_rgb), 0);
        check("rst_bg_rd_addr", int'(bg_rd_addr), 0);
        check("rst_sheet_addr", int'(sheet_addr), 0);
        repeat (3) @(posedge clk);
        #1;
        release_reset();

        for (int i = 0; i < 640; i++) issue(i, 40, 0, 1'b1);
        issue(3, 5, 0, 1'b1);
        issue(639, 0, 15, 1'b1);
        issue(20, 0, 0, 1'b1);
        issue(40, 0, 0, 1'b1);
        issue(45, 7, 0, 1'b0);
        issue(100, 479, 0, 1'b1);
        issue(100, 480, 0, 1'b1);
        issue(10, 10, 0, 1'b1);
        issue(11, 10, 0, 1'b0);
        issue(12, 10, 0, 1'b1);

        for (int i = 0; i < 2000; i++)
            issue($urandom_range(0, 639), $urandom_range(0, 511), $urandom_range(0, 15),
                  $urandom_range(0, 4) != 0);

        for (int i = 0; i < 20; i++) issue(200 + i, 64, 3, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_pix_valid", int'(pix_valid), 0);
        check("mid_rst_pix_opaque", int'(pix_opaque), 0);
        check("mid_rst_pix_rgb", int'(pix_rgb), 0);
        check("mid_rst_bg_rd_addr", int'(bg_rd_addr), 0);
        check("mid_rst_sheet_addr", int'(sheet_addr), 0);
        rd_q.delete();
        sh_q.delete();
        px_q.delete();
        repeat (3) @(posedge clk);
        #1;
        release_reset();
        for (int i = 0; i < 50; i++) issue(300 + i, 100, 0, 1'b1);

        for (int i = 0; i < 10 && (rd_q.size() + sh_q.size() + px_q.size()) > 0; i++)
            @(posedge clk);
        @(negedge clk);
        #1;
        if ((rd_q.size() + sh_q.size() + px_q.size()) > 0) begin
            checks++;
            failures++;
            $display("FAIL drain got=%0d-pending expected=0-pending",
                     rd_q.size() + sh_q.size() + px_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
